// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: the queued character record and
// the default character-timeout length.
package uart_pkg;

   localparam int RX_DATA_SIZE       = 8;
   localparam int RX_TIMEOUT_DEFAULT = 640;

   // Field order fixes the packed layout {break, stop, parity, data} in the RAM.
   typedef struct packed {
      logic                    break_err;
      logic                    stop_err;
      logic                    parity_err;
      logic [RX_DATA_SIZE-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO: one write port and a registered read
// port whose output holds the last value read until the next read.
module uart_fifo_ram #(
   parameter int WIDTH     = 11,
   parameter int DEPTH     = 16,
   parameter int ADDR_SIZE = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDR_SIZE-1:0] wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_SIZE-1:0] rd_addr,
   output logic [WIDTH-1:0]     rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [WIDTH-1:0] rd_data_d;

   // Contents are deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_receiver: queues characters with their error flags
// and reports level, threshold, character timeout and sticky overrun status.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_SIZE   = RX_DATA_SIZE,
   parameter int DEPTH       = 16,
   parameter int ADDR_SIZE   = $clog2(DEPTH),
   parameter int TIMEOUT_CYC = RX_TIMEOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_done,
   input  logic [DATA_SIZE-1:0] data_in,
   input  logic                 parity_err_in,
   input  logic                 stop_err_in,
   input  logic                 break_err_in,
   input  logic                 rd_en,
   input  logic [ADDR_SIZE:0]   threshold,
   input  logic                 overrun_clr,
   output logic [DATA_SIZE-1:0] rd_data,
   output logic                 rd_parity_err,
   output logic                 rd_stop_err,
   output logic                 rd_break_err,
   output logic                 rd_valid,
   output logic [ADDR_SIZE:0]   count,
   output logic                 empty,
   output logic                 full,
   output logic                 rx_level_irq,
   output logic                 rx_timeout,
   output logic                 overrun
);

   localparam int CNT_W = ADDR_SIZE + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC);

   logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [2:0]           err_q, err_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic                 overrun_q, overrun_d;
   logic                 rd_valid_q, rd_valid_d;

   logic      rd_accept;
   logic      wr_accept;
   logic      drop;
   logic      ram_wr_en;
   rx_entry_t wr_entry;
   rx_entry_t rd_entry;

   assign empty        = (count_q == '0);
   assign full         = (count_q == FULL_CNT);
   assign rx_level_irq = (threshold != '0) && (count_q >= threshold);
   assign rx_timeout   = (tmr_q == TMR_MAX) && !empty;

   // The receiver flags errors one cycle ahead of rx_done, so err_q lines them up.
   // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
   always_comb begin
      rd_accept = rd_en & ~empty;
      wr_accept = rx_done & (~full | rd_accept);
      drop      = rx_done & full & ~rd_en;
      ram_wr_en = wr_accept & ~reset;
      wr_entry  = {err_q, data_in};

      err_d      = {break_err_in, stop_err_in, parity_err_in};
      rd_valid_d = rd_accept;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overrun_d  = overrun_q;
      tmr_d      = tmr_q;

      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (drop) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end

      // Idle timer restarts on any traffic and only runs while data is waiting.
      if (wr_accept || rd_accept || empty) begin
         tmr_d = '0;
      end else if (tmr_q != TMR_MAX) begin
         tmr_d = tmr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= '0;
         tmr_q      <= '0;
         overrun_q  <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_q      <= err_d;
         tmr_q      <= tmr_d;
         overrun_q  <= overrun_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   uart_fifo_ram #(
      .WIDTH     ($bits(rx_entry_t)),
      .DEPTH     (DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (ram_wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_entry)
   );

   assign rd_data       = rd_entry.data;
   assign rd_parity_err = rd_entry.parity_err;
   assign rd_stop_err   = rd_entry.stop_err;
   assign rd_break_err  = rd_entry.break_err;
   assign rd_valid      = rd_valid_q;
   assign count         = count_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table for basic traffic plus
// scoreboard-checked sequences for overrun, wrap, threshold, timeout and reset.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int TO    = 640;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_done = 1'b0;
   logic [7:0] data_in = '0;
   logic       parity_err_in = 1'b0;
   logic       stop_err_in = 1'b0;
   logic       break_err_in = 1'b0;
   logic       rd_en = 1'b0;
   logic [4:0] threshold = '0;
   logic       overrun_clr = 1'b0;
   logic [7:0] rd_data;
   logic       rd_parity_err, rd_stop_err, rd_break_err, rd_valid;
   logic [4:0] count;
   logic       empty, full, rx_level_irq, rx_timeout, overrun;

   int n_cmp = 0;
   int n_err = 0;

   logic [10:0] sb[$];
   int          m_count = 0;
   logic        m_over = 1'b0;
   logic [2:0]  m_err = '0;

   typedef struct {
      logic       rx;
      logic [7:0] d;
      logic [2:0] err;
      logic       rd;
      logic [4:0] exp_count;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic [2:0] exp_flags;
   } vec_t;

   vec_t vecs[18];

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_SIZE(8), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_done       (rx_done),
      .data_in       (data_in),
      .parity_err_in (parity_err_in),
      .stop_err_in   (stop_err_in),
      .break_err_in  (break_err_in),
      .rd_en         (rd_en),
      .threshold     (threshold),
      .overrun_clr   (overrun_clr),
      .rd_data       (rd_data),
      .rd_parity_err (rd_parity_err),
      .rd_stop_err   (rd_stop_err),
      .rd_break_err  (rd_break_err),
      .rd_valid      (rd_valid),
      .count         (count),
      .empty         (empty),
      .full          (full),
      .rx_level_irq  (rx_level_irq),
      .rx_timeout    (rx_timeout),
      .overrun       (overrun)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; the reference model predicts the result before the
   // edge and every status output is compared #1 after it.
   task automatic applyStimulus(input logic rx, input logic [7:0] d, input logic [2:0] err,
                                input logic rd, input logic clr);
      logic        racc;
      logic        drop;
      logic [10:0] exp;
      rx_done       = rx;
      data_in       = d;
      break_err_in  = err[2];
      stop_err_in   = err[1];
      parity_err_in = err[0];
      rd_en         = rd;
      overrun_clr   = clr;
      racc = !reset && rd && (m_count != 0);
      if (reset) begin
         sb.delete();
         m_count = 0;
         m_over  = 1'b0;
         m_err   = '0;
      end else begin
         drop = rx && (m_count == DEPTH) && !rd;
         if (rx && ((m_count < DEPTH) || racc)) begin
            sb.push_back({m_err, d});
            m_count++;
         end
         if (drop) m_over = 1'b1;
         else if (clr) m_over = 1'b0;
         if (racc) m_count--;
         m_err = err;
      end
      @(posedge clk);
      #1;
      checkOutput("rd_valid", 32'(rd_valid), 32'(racc));
      if (racc) begin
         if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            exp = sb.pop_front();
            checkOutput("sb_data", 32'(rd_data), 32'(exp[7:0]));
            checkOutput("sb_flags", 32'({rd_break_err, rd_stop_err, rd_parity_err}), 32'(exp[10:8]));
         end
      end
      checkOutput("count", 32'(count), 32'(m_count));
      checkOutput("empty", 32'(empty), 32'(m_count == 0));
      checkOutput("full", 32'(full), 32'(m_count == DEPTH));
      checkOutput("overrun", 32'(overrun), 32'(m_over));
      checkOutput("irq", 32'(rx_level_irq), 32'((threshold != 0) && (m_count >= int'(threshold))));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h41, 3'b000, 1'b0, 5'd1, 1'b0, 8'h00, 3'b000};
      vecs[1]  = '{1'b1, 8'h42, 3'b000, 1'b0, 5'd2, 1'b0, 8'h00, 3'b000};
      vecs[2]  = '{1'b1, 8'h43, 3'b000, 1'b0, 5'd3, 1'b0, 8'h00, 3'b000};
      vecs[3]  = '{1'b0, 8'h00, 3'b000, 1'b1, 5'd2, 1'b1, 8'h41, 3'b000};
      vecs[4]  = '{1'b0, 8'h00, 3'b000, 1'b1, 5'd1, 1'b1, 8'h42, 3'b000};
      vecs[5]  = '{1'b0, 8'h00, 3'b000, 1'b1, 5'd0, 1'b1, 8'h43, 3'b000};
      vecs[6]  = '{1'b0, 8'h00, 3'b000, 1'b1, 5'd0, 1'b0, 8'h43, 3'b000};
      vecs[7]  = '{1'b1, 8'h44, 3'b000, 1'b1, 5'd1, 1'b0, 8'h43, 3'b000};
      vecs[8]  = '{1'b1, 8'h45, 3'b000, 1'b1, 5'd1, 1'b1, 8'h44, 3'b000};
      vecs[9]  = '{1'b0, 8'h00, 3'b000, 1'b1, 5'd0, 1'b1, 8'h45, 3'b000};
      vecs[10] = '{1'b0, 8'h00, 3'b001, 1'b0, 5'd0, 1'b0, 8'h45, 3'b000};
      vecs[11] = '{1'b1, 8'h55, 3'b000, 1'b0, 5'd1, 1'b0, 8'h45, 3'b000};
      vecs[12] = '{1'b1, 8'h66, 3'b000, 1'b0, 5'd2, 1'b0, 8'h45, 3'b000};
      vecs[13] = '{1'b0, 8'h00, 3'b000, 1'b1, 5'd1, 1'b1, 8'h55, 3'b001};
      vecs[14] = '{1'b0, 8'h00, 3'b000, 1'b1, 5'd0, 1'b1, 8'h66, 3'b000};
      vecs[15] = '{1'b0, 8'h00, 3'b110, 1'b0, 5'd0, 1'b0, 8'h66, 3'b000};
      vecs[16] = '{1'b1, 8'h77, 3'b000, 1'b0, 5'd1, 1'b0, 8'h66, 3'b000};
      vecs[17] = '{1'b0, 8'h00, 3'b000, 1'b1, 5'd0, 1'b1, 8'h77, 3'b110};

      // Reset state.
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
      checkOutput("rst_flags", 32'({rd_break_err, rd_stop_err, rd_parity_err}), 32'h0);
      checkOutput("rst_timeout", 32'(rx_timeout), 32'h0);

      // Basic traffic and error-flag alignment from the vector table.
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].rx, vecs[i].d, vecs[i].err, vecs[i].rd, 1'b0);
         checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
         checkOutput($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
         checkOutput($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
         checkOutput($sformatf("vec%0d_flags", i),
                     32'({rd_break_err, rd_stop_err, rd_parity_err}), 32'(vecs[i].exp_flags));
      end

      // Fill to full, overflow, clear overrun, then write with a same-cycle pop.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h80 + i), 3'b000, 1'b0, 1'b0);
      checkOutput("full_at_16", 32'(full), 32'h1);
      applyStimulus(1'b1, 8'hEE, 3'b000, 1'b0, 1'b0);
      checkOutput("drop_overrun", 32'(overrun), 32'h1);
      checkOutput("drop_count", 32'(count), 32'd16);
      applyStimulus(1'b1, 8'hED, 3'b000, 1'b0, 1'b1);
      checkOutput("set_beats_clr", 32'(overrun), 32'h1);
      applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
      checkOutput("overrun_clr", 32'(overrun), 32'h0);
      applyStimulus(1'b1, 8'hEF, 3'b000, 1'b1, 1'b0);
      checkOutput("full_wr_rd_count", 32'(count), 32'd16);
      checkOutput("full_wr_rd_overrun", 32'(overrun), 32'h0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      checkOutput("drained_empty", 32'(empty), 32'h1);

      // Interleaved traffic across the pointer wrap.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'(8'hB0 + i), 3'(i % 8), 1'b1, 1'b0);
         checkOutput("count_bound", 32'(count <= 5'd16), 32'h1);
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      checkOutput("wrap_empty", 32'(empty), 32'h1);

      // Level threshold and character timeout.
      threshold = 5'd4;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 3'b000, 1'b0, 1'b0);
      checkOutput("irq_at_3", 32'(rx_level_irq), 32'h0);
      applyStimulus(1'b1, 8'hC3, 3'b000, 1'b0, 1'b0);
      checkOutput("irq_at_4", 32'(rx_level_irq), 32'h1);
      threshold = 5'd0;
      #1;
      checkOutput("irq_thr0", 32'(rx_level_irq), 32'h0);
      threshold = 5'd4;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      idle(TO - 1);
      checkOutput("timeout_639", 32'(rx_timeout), 32'h0);
      idle(1);
      checkOutput("timeout_640", 32'(rx_timeout), 32'h1);
      idle(1);
      checkOutput("timeout_sat", 32'(rx_timeout), 32'h1);
      applyStimulus(1'b1, 8'hC4, 3'b000, 1'b0, 1'b0);
      checkOutput("timeout_wr_clr", 32'(rx_timeout), 32'h0);
      idle(TO);
      checkOutput("timeout_again", 32'(rx_timeout), 32'h1);
      applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      checkOutput("timeout_rd_clr", 32'(rx_timeout), 32'h0);
      checkOutput("timeout_rd_count", 32'(count), 32'd1);
      applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      idle(TO + 20);
      checkOutput("timeout_empty", 32'(rx_timeout), 32'h0);

      // Reset with five entries queued, a pop request, and a pending error.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hD0 + i), 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      reset = 1'b1;
      applyStimulus(1'b1, 8'h99, 3'b001, 1'b1, 1'b0);
      reset = 1'b0;
      checkOutput("midrst_count", 32'(count), 32'd0);
      checkOutput("midrst_empty", 32'(empty), 32'h1);
      checkOutput("midrst_valid", 32'(rd_valid), 32'h0);
      checkOutput("midrst_rd_data", 32'(rd_data), 32'h0);
      applyStimulus(1'b1, 8'h12, 3'b000, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      checkOutput("postrst_data", 32'(rd_data), 32'h12);
      checkOutput("postrst_flags", 32'({rd_break_err, rd_stop_err, rd_parity_err}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
